// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants used as parameter defaults
package fir_pkg;

    localparam int unsigned FIR_DATA_W        = 16;
    localparam int unsigned FIR_STROBE_PERIOD = 16;
    localparam int unsigned FIR_FIFO_DEPTH    = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered head and occupancy count
//
// Ports:
//   clk    system clock, posedge
//   reset  asynchronous active-low reset
//   push   write wdata; ignored when full unless pop is also asserted
//   pop    consume the head entry; ignored when empty
//   wdata  entry to write
//   rdata  head entry (0 while empty)
//   level  occupancy 0..DEPTH
//   full   level == DEPTH
//   empty  level == 0
module sync_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W,
    parameter int unsigned DEPTH  = FIR_FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A push into a full FIFO is allowed when the head leaves in the same
    // cycle: the write lands in the slot being vacated (wr_ptr == rd_ptr).
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Gate the head so stale memory never shows after reset or a drain.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Power-of-2 depth lets the pointers wrap by plain overflow.
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_capture.sv
// rtl/fir_sample_capture.sv - captures FIR results on strobe rising edges into a valid/ready FIFO
//
// Optional feature macro: STROBE_CHECK_EN (strobe interval check driving period_err)
//
// Ports:
//   clk         system clock, posedge
//   reset       asynchronous active-low reset
//   strobe_in   sample-enable strobe; each rising edge captures data_in
//   data_in     FIR result, valid while strobe_in is high
//   out_data    FIFO head sample
//   out_valid   FIFO non-empty
//   out_ready   downstream accepts out_data this cycle
//   fill_level  FIFO occupancy 0..DEPTH
//   overflow    sticky: a capture was dropped because the FIFO was full
//   period_err  sticky: a strobe interval differed from PERIOD (0 without STROBE_CHECK_EN)
module fir_sample_capture
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W,
    parameter int unsigned DEPTH  = FIR_FIFO_DEPTH,
    parameter int unsigned PERIOD = FIR_STROBE_PERIOD,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LW-1:0]     fill_level,
    output logic              overflow,
    output logic              period_err
);

    logic strobe_d;
    logic cap;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    // strobe_d clears on reset, so a strobe already high on the first
    // active cycle still counts as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_d <= 1'b0;
        end else begin
            strobe_d <= strobe_in;
        end
    end

    assign cap       = strobe_in & ~strobe_d;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap),
        .pop   (pop),
        .wdata (data_in),
        .rdata (out_data),
        .level (fill_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A capture is only lost when full and nothing leaves this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (cap && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef STROBE_CHECK_EN
    localparam int unsigned CW = $clog2(PERIOD) + 1;

    logic [CW-1:0] interval;
    logic          seen_edge;

    // interval holds the number of cycles since the last capture at the
    // moment of the next one: reloaded to 1 on cap, +1 every other cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            interval   <= '0;
            seen_edge  <= 1'b0;
            period_err <= 1'b0;
        end else if (cap) begin
            interval  <= CW'(1);
            seen_edge <= 1'b1;
            if (seen_edge && (interval != CW'(PERIOD))) begin
                period_err <= 1'b1;
            end
        end else if (interval != '1) begin
            interval <= interval + CW'(1);
        end
    end
`else
    logic unused_period;

    assign unused_period = (PERIOD != 0);
    assign period_err    = 1'b0;
`endif

endmodule

// File: doc/fir_sample_capture.md
Name: fir_sample_capture

Overview:
- Consumer end of the FIR output-enable strobe.
- Detects each rising edge of the periodic sample strobe, which is high for one cycle every PERIOD cycles, and captures the filter result on that edge.
- Buffers captured samples in a small FIFO and presents them downstream on a valid/ready handshake.
- Sits between the FIR datapath/strobe counter and any downstream sink, e.g. a serializer or a test harness.

Parameters:
- DATA_W, 16: width of the captured FIR sample.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- PERIOD, 16: expected cycles between strobe rising edges. Used only when STROBE_CHECK_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- strobe_in  input  1  sample-enable strobe from the strobe counter.
- data_in  input  DATA_W  FIR result; valid whenever strobe_in is high.
- out_data  output  DATA_W  FIFO head sample.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data this cycle.
- fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full.
- period_err  output  1  sticky: the strobe interval differed from PERIOD.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While reset=0: FIFO empty, pointers 0, strobe_d=0, out_valid=0, out_data=0, fill_level=0, overflow=0, period_err=0, interval counter=0.
  - Deassertion is assumed synchronous to clk upstream.
  - Reset mid-operation discards all buffered samples immediately.
- Edge detect:
  - Register strobe_d <= strobe_in.
  - cap = strobe_in & ~strobe_d.
  - A strobe held high for several cycles yields exactly one capture.
  - The first cycle after reset with strobe_in=1 counts as an edge.
- Push: on cap, data_in is written at the write pointer in the same posedge.
- Pop: pop = out_valid & out_ready; the read pointer advances.
- Output timing: out_data is the registered FIFO head, not fall-through.
  - Capture at edge N makes out_valid=1 after edge N (latency 1 cycle).
  - After a pop, out_data shows the next entry after the same edge.
- out_valid = (fill_level != 0).
- fill_level: +1 on accepted push, -1 on pop, unchanged on both or neither.
- Full:
  - cap with fill_level==DEPTH and no pop: sample dropped, overflow<=1, contents unchanged.
  - cap and pop in the same cycle while full: push accepted, level stays DEPTH, no overflow.
- Empty: pop impossible (out_valid=0); out_ready is ignored.
- Pointers: wrap modulo DEPTH; full/empty are derived from fill_level, not from pointer comparison.
- overflow and period_err: cleared only by reset.

Optional Feature:
- Macro: STROBE_CHECK_EN.
- Defined:
  - Interval counter of width $clog2(PERIOD)+1 increments each cycle, saturating at all-ones, and resets to 1 on cap.
  - On each cap other than the first after reset, if counter != PERIOD, period_err<=1.
  - A first-edge flag tracks whether any edge has been seen since reset.
- Undefined: no counter or flag logic is built; period_err is tied to 0.

Decomposition:
- Shared package fir_pkg:
  - FIR_DATA_W = 16.
  - FIR_STROBE_PERIOD = 16.
  - Default FIFO depth constant.
  - These serve as parameter defaults for this block and the strobe counter.
- One natural sub-module, sync_fifo:
  - Parameterized DATA_W/DEPTH.
  - Ports: push, pop, wdata, rdata, level, full, empty.
  - The top level holds edge detect, overflow, and period check.

Test Plan:
1. Reset & first sample: reset=0 for 3 cycles, then 1; strobe pulse 1 cycle with data_in=16'h1234, out_ready=0. Expect out_valid=1, out_data=16'h1234, fill_level=1 one edge later; overflow=0.
2. Stream at period: strobe every 16 cycles with data 1,2,3,..., out_ready=1. Expect out_data sequence 1,2,3 in order, fill_level never above 1, period_err=0 with STROBE_CHECK_EN.
3. Overflow: out_ready=0, 5 strobes with data A..E, DEPTH=4. Expect fill_level=4, overflow=1; drain yields A,B,C,D; E is lost.
4. Full plus simultaneous pop: FIFO full with out_ready=1 on the strobe cycle. Expect level stays 4, overflow stays 0, new sample appears last.
5. Long strobe and bad period: strobe high for 3 cycles gives exactly 1 capture. Next edge 10 cycles later gives period_err=1 (macro defined) or 0 (macro undefined).
6. Reset mid-operation: FIFO holding 3 samples, assert reset for 1 cycle asynchronously between edges. Expect immediate out_valid=0, fill_level=0, overflow=0, period_err=0.
